// File: rtl/tinker_arb_pkg.sv
// Shared types and widths for the Tinker memory-port arbiter.
package tinker_arb_pkg;

   localparam int unsigned IF_W = 32;
   localparam int unsigned D_W  = 64;
   localparam int unsigned A_W  = 64;

   typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

   typedef struct packed {
      logic           we;
      logic [A_W-1:0] addr;
      logic [D_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter; slave = arbiter, master = environment.
interface tinker_mem_arbiter_if;
   import tinker_arb_pkg::*;

   logic            if_req;
   logic [A_W-1:0]  if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [IF_W-1:0] if_rdata;

   logic            d_req;
   logic            d_we;
   logic [A_W-1:0]  d_addr;
   logic [D_W-1:0]  d_wdata;
   logic            d_gnt;
   logic            d_rvalid;
   logic [D_W-1:0]  d_rdata;

   logic            m_req;
   logic            m_we;
   logic [A_W-1:0]  m_addr;
   logic [D_W-1:0]  m_wdata;
   logic [D_W-1:0]  m_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             m_req, m_we, m_addr, m_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             m_req, m_we, m_addr, m_wdata
   );

endinterface

// File: rtl/tinker_arb_starve_ctr.sv
// Saturating count of cycles a fetch has waited; hit_o flags that fetch must win next.
module tinker_arb_starve_ctr #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic wait_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (wait_i && (cnt_q < CNT_W'(MAX_WAIT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares one fixed-latency memory port between fetch and data; data has priority.
// Define TINKER_ARB_STARVE_GUARD_EN to let a fetch that waited MAX_WAIT cycles win.
module tinker_mem_arbiter
   import tinker_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT  = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   tinker_mem_arbiter_if.slave bus
);

   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   generate
      if (MEM_LAT < 1) begin : g_lat_chk
         $error("tinker_mem_arbiter: MEM_LAT must be >= 1");
      end
      if (MAX_WAIT < 1) begin : g_wait_chk
         $error("tinker_mem_arbiter: MAX_WAIT must be >= 1");
      end
   endgenerate

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             we_q, we_d;

   logic     issue_slot;
   logic     resp;
   logic     pick_if;
   logic     pick_d;
   logic     starve_hit;
   mem_cmd_t cmd;

`ifdef TINKER_ARB_STARVE_GUARD_EN
   tinker_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk    (clk),
      .reset  (reset),
      .wait_i (bus.if_req & ~pick_if),
      .clr_i  (pick_if),
      .hit_o  (starve_hit)
   );
`else
   assign starve_hit = 1'b0;
`endif

   // Winner selection and memory command; everything is held at 0 while in reset.
   always_comb begin
      issue_slot = !reset && ((state_q == ST_IDLE) || (lat_q == '0));
      resp       = !reset && (state_q == ST_WAIT) && (lat_q == '0);
      pick_d     = issue_slot && bus.d_req && !(starve_hit && bus.if_req);
      pick_if    = issue_slot && bus.if_req && !pick_d;

      cmd = '0;
      if (pick_d) begin
         cmd.we    = bus.d_we;
         cmd.addr  = bus.d_addr;
         cmd.wdata = bus.d_wdata;
      end else if (pick_if) begin
         cmd.addr  = bus.if_addr;
      end
   end

   // Next-state: count down the outstanding access, otherwise issue or go idle.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      lat_d   = lat_q;
      we_d    = we_q;
      if ((state_q == ST_WAIT) && (lat_q != '0)) begin
         lat_d = lat_q - LAT_W'(1);
      end else if (pick_d || pick_if) begin
         state_d = ST_WAIT;
         owner_d = pick_d ? OWN_D : OWN_IF;
         lat_d   = LAT_W'(MEM_LAT - 1);
         we_d    = cmd.we;
      end else begin
         state_d = ST_IDLE;
         owner_d = OWN_NONE;
         lat_d   = '0;
         we_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         lat_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lat_q   <= lat_d;
         we_q    <= we_d;
      end
   end

   assign bus.if_gnt    = pick_if;
   assign bus.d_gnt     = pick_d;
   assign bus.m_req     = pick_if | pick_d;
   assign bus.m_we      = cmd.we;
   assign bus.m_addr    = cmd.addr;
   assign bus.m_wdata   = cmd.wdata;

   assign bus.if_rvalid = resp && (owner_q == OWN_IF);
   assign bus.d_rvalid  = resp && (owner_q == OWN_D);
   assign bus.if_rdata  = bus.if_rvalid ? bus.m_rdata[IF_W-1:0] : '0;
   assign bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Scoreboard bench for tinker_mem_arbiter: directed scenarios then randomized traffic.
module tb_tinker_mem_arbiter;
   import tinker_arb_pkg::*;

   localparam int unsigned MEM_LAT  = 2;
   localparam int unsigned MAX_WAIT = 4;

   logic clk = 1'b0;
   logic reset;

   tinker_mem_arbiter_if bus ();

   tinker_mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int unsigned due;
      bit          is_d;
      logic [63:0] data;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [63:0] mem [logic [63:0]];
   logic [63:0] rd_pipe [int unsigned];

   int unsigned next_free = 0;
   int unsigned wait_cnt  = 0;

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   // Reference model: one access per MEM_LAT cycles, data first unless fetch waited too long.
   always @(negedge clk) begin
      bit          w_if, w_d, guard_fetch;
      logic [63:0] e_addr, e_wdata, e_data, tmp;
      logic        e_we;
      if (reset) begin
         chk("reset_ctl", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.m_req, bus.m_we}, 64'd0);
         chk("reset_addr", bus.m_addr, 64'd0);
         chk("reset_wdata", bus.m_wdata, 64'd0);
         chk("reset_rdata", {bus.if_rdata, 32'd0} | bus.d_rdata, 64'd0);
         next_free = cyc + 1;
         wait_cnt  = 0;
         exp_q.delete();
      end else begin
         w_if = 1'b0;
         w_d  = 1'b0;
`ifdef TINKER_ARB_STARVE_GUARD_EN
         guard_fetch = (wait_cnt >= MAX_WAIT);
`else
         guard_fetch = 1'b0;
`endif
         if (cyc >= next_free) begin
            if (bus.if_req && (guard_fetch || !bus.d_req)) w_if = 1'b1;
            else if (bus.d_req) w_d = 1'b1;
         end
         e_addr  = w_d ? bus.d_addr : (w_if ? bus.if_addr : 64'd0);
         e_we    = w_d && bus.d_we;
         e_wdata = w_d ? bus.d_wdata : 64'd0;
         chk("if_gnt", bus.if_gnt, w_if);
         chk("d_gnt", bus.d_gnt, w_d);
         chk("m_req", bus.m_req, w_if | w_d);
         chk("m_we", bus.m_we, e_we);
         chk("m_addr", bus.m_addr, e_addr);
         chk("m_wdata", bus.m_wdata, e_wdata);
         if (w_if || w_d) begin
            tmp = mem_rd(e_addr);
            if (w_if) e_data = {32'd0, tmp[31:0]};
            else if (e_we) e_data = 64'd0;
            else e_data = tmp;
            exp_q.push_back('{due: cyc + MEM_LAT, is_d: w_d, data: e_data});
            next_free = cyc + MEM_LAT;
         end
         if (w_if) wait_cnt = 0;
         else if (bus.if_req && wait_cnt < MAX_WAIT) wait_cnt++;
      end
      // Backing memory reacts to what the DUT actually drives.
      if (bus.m_req) begin
         if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
         else rd_pipe[cyc + MEM_LAT] = mem_rd(bus.m_addr);
      end
   end

   // Response monitor: each rvalid must match the oldest expected response.
   always @(negedge clk) begin
      rsp_t r;
      if (!reset) begin
         if (bus.if_rvalid || bus.d_rvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL spurious_rvalid cyc=%0d actual if=%0b d=%0b required none",
                        cyc, bus.if_rvalid, bus.d_rvalid);
            end else begin
               r = exp_q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(r.due));
               chk("rsp_owner", {bus.if_rvalid, bus.d_rvalid}, r.is_d ? 64'd1 : 64'd2);
               chk("rsp_data", r.is_d ? bus.d_rdata : {32'd0, bus.if_rdata}, r.data);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            $display("FAIL missing_rvalid cyc=%0d actual none required due=%0d", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
         end
      end
   end

   // Memory read data appears MEM_LAT cycles after the access; garbage otherwise.
   always @(posedge clk) begin
      #1;
      if (rd_pipe.exists(cyc)) begin
         bus.m_rdata = rd_pipe[cyc];
         rd_pipe.delete(cyc);
      end else begin
         bus.m_rdata = {$urandom, $urandom};
      end
   end

   task automatic step();
      bit ig, dg;
      @(negedge clk);
      ig = bus.if_gnt;
      dg = bus.d_gnt;
      @(posedge clk);
      #1;
      if (ig) bus.if_req = 1'b0;
      if (dg) bus.d_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic issue_if(input logic [63:0] a);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
   endtask

   task automatic issue_d(input logic we, input logic [63:0] a, input logic [63:0] wd);
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = wd;
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = 64'($urandom_range(0, 15)) * 64'd8;
      if ($urandom_range(0, 3) == 0) a = a | 64'hFFFF_FFFF_0000_0000;
      return a;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual running required finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      mem[64'h2000] = 64'h0000_0000_1234_5678;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      issue_if(64'h2000);
      idle(5);

      issue_if(64'h4000);
      issue_d(1'b0, 64'h7FFF8, 64'h1111_2222_3333_4444);
      idle(8);

      issue_d(1'b1, 64'h100, 64'h0000_0000_DEAD_BEEF);
      idle(4);
      issue_d(1'b0, 64'h100, 64'd0);
      idle(4);

      issue_if(64'h3000);
      issue_d(1'b0, 64'h8, 64'd0);
      repeat (16) begin
         step();
         if (!bus.d_req) issue_d(1'b0, rand_addr(), 64'($urandom));
      end
      for (int k = 0; k < 6 && bus.d_req; k++) step();
      idle(8);

      issue_d(1'b0, 64'h18, 64'd0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      issue_d(1'b0, 64'h20, 64'd0);
      idle(5);

      for (int i = 0; i < 3; i++) begin
         issue_d(1'b0, 64'h40 + 64'(i) * 64'd8, 64'd0);
         for (int k = 0; k < 10 && bus.d_req; k++) step();
      end
      idle(5);

      repeat (3000) begin
         if (!bus.if_req && $urandom_range(0, 99) < 40) issue_if(rand_addr() + 64'($urandom_range(0, 7)));
         if (!bus.d_req && $urandom_range(0, 99) < 50)
            issue_d(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
         if ($urandom_range(0, 299) == 0) begin
            reset      = 1'b1;
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            step();
            reset = 1'b0;
         end
         step();
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      idle(6);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
